// File: rtl/fader_motor_arbiter.sv
// fader_motor_arbiter
//   Current-budget scheduler for the motor fader array. Up to MAX_ACTIVE
//   channels may drive their motor at once; drive slots are handed out
//   round-robin, preempted after SLOT_CYCLES when others wait, and
//   optionally held idle for GUARD_CYCLES after each release.
//
//   Optional feature macro: FADER_ARB_GUARD_EN
//     defined   : released slots pass through GUARD for GUARD_CYCLES cycles.
//     undefined : released slots return straight to IDLE; GUARD_CYCLES has
//                 no effect and the guard counters are not built.
//
//   Request/grant contract: a channel requests by holding req high
//   (req = (up_in | down_in) & faders_en). The grant is a level. It stays
//   high while req stays high, until the slot's time slice expires with other
//   requests waiting. Dropping req is the only way a channel gives up its
//   slot voluntarily, and grant falls on the first edge that sees req low.
//   Motor pins are the channel inputs ANDed with the registered grant; no
//   other path connects them.
//
//   dbg_slot_state packs the per-slot FSM state, 2 bits per slot, slot 0 in
//   the low bits (0 = IDLE, 1 = ACTIVE, 2 = GUARD).
module fader_motor_arbiter #(
  parameter int N_CH         = 8,
  parameter int MAX_ACTIVE   = 2,
  parameter int SLOT_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         faders_en,
  input  logic [N_CH-1:0]         pwm_in,
  input  logic [N_CH-1:0]         up_in,
  input  logic [N_CH-1:0]         down_in,
  output logic [N_CH-1:0]         pwm_out,
  output logic [N_CH-1:0]         up_out,
  output logic [N_CH-1:0]         down_out,
  output logic [N_CH-1:0]         grant,
  output logic [3:0]              active_cnt,
  output logic                    waiting,
  output logic [2*MAX_ACTIVE-1:0] dbg_slot_state
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = 20;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);

`ifdef FADER_ARB_GUARD_EN
  localparam int GCNT_W = 16;
  localparam logic [GCNT_W-1:0] GUARD_LAST = GCNT_W'(GUARD_CYCLES - 1);
`else
  // GUARD_CYCLES has no effect in this build; this null block only keeps the
  // parameter referenced.
  if (GUARD_CYCLES < 0) begin : g_guard_cycles_unused
  end
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GUARD  = 2'd2
  } slot_state_t;

  // Registered slot state
  slot_state_t      r_state [MAX_ACTIVE];
  logic [CH_W-1:0]  r_ch    [MAX_ACTIVE];
  logic [CNT_W-1:0] r_cnt   [MAX_ACTIVE];
`ifdef FADER_ARB_GUARD_EN
  logic [GCNT_W-1:0] r_gcnt [MAX_ACTIVE];
`endif
  logic [CH_W-1:0]  r_rr_ptr;
  logic [N_CH-1:0]  r_grant;
  logic [3:0]       r_active_cnt;
  logic             r_waiting;

  // Next-state and decode wires
  slot_state_t      w_state_nxt [MAX_ACTIVE];
  logic [CH_W-1:0]  w_ch_nxt    [MAX_ACTIVE];
  logic [CNT_W-1:0] w_cnt_nxt   [MAX_ACTIVE];
`ifdef FADER_ARB_GUARD_EN
  logic [GCNT_W-1:0] w_gcnt_nxt [MAX_ACTIVE];
`endif
  logic [N_CH-1:0]       w_req;
  logic [N_CH-1:0]       w_elig;
  logic [N_CH-1:0]       w_grant_nxt;
  logic [CH_W-1:0]       w_scan_idx;
  logic                  w_pick_vld;
  logic [CH_W-1:0]       w_pick_ch;
  logic [MAX_ACTIVE-1:0] w_alloc;
  logic                  w_alloc_done;
  logic [3:0]            w_active_nxt;
  logic                  w_waiting_nxt;
  logic [CH_W-1:0]       w_rr_nxt;

  // Request and eligibility: a channel already holding a slot is never a candidate
  always_comb begin
    w_req  = (up_in | down_in) & faders_en;
    w_elig = w_req & ~r_grant;
  end

  // Round-robin pick: first eligible channel after rr_ptr, wrapping at N_CH-1
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_ch  = '0;
    w_scan_idx = '0;
    for (int k = 1; k <= N_CH; k++) begin
      w_scan_idx = CH_W'((int'(r_rr_ptr) + k) % N_CH);
      if (!w_pick_vld && w_elig[w_scan_idx]) begin
        w_pick_vld = 1'b1;
        w_pick_ch  = w_scan_idx;
      end
    end
  end

  // Slot allocation: at most one new grant per cycle, to the lowest IDLE slot
  always_comb begin
    w_alloc      = '0;
    w_alloc_done = 1'b0;
    for (int s = 0; s < MAX_ACTIVE; s++) begin
      if (w_pick_vld && !w_alloc_done && (r_state[s] == S_IDLE)) begin
        w_alloc[s]   = 1'b1;
        w_alloc_done = 1'b1;
      end
    end
  end

  // Per-slot FSM next state: grant, time slice, release, guard
  always_comb begin
    for (int s = 0; s < MAX_ACTIVE; s++) begin
      w_state_nxt[s] = r_state[s];
      w_ch_nxt[s]    = r_ch[s];
      w_cnt_nxt[s]   = r_cnt[s];
`ifdef FADER_ARB_GUARD_EN
      w_gcnt_nxt[s]  = r_gcnt[s];
`endif
      case (r_state[s])
        S_IDLE: begin
          if (w_alloc[s]) begin
            w_state_nxt[s] = S_ACTIVE;
            w_ch_nxt[s]    = w_pick_ch;
            w_cnt_nxt[s]   = '0;
          end
        end
        S_ACTIVE: begin
          // Release on request drop (covers enable drop) or slice expiry with
          // someone waiting; an expired slice with nobody waiting just restarts.
          if (!w_req[r_ch[s]] || ((r_cnt[s] == SLOT_LAST) && r_waiting)) begin
            w_cnt_nxt[s] = '0;
`ifdef FADER_ARB_GUARD_EN
            w_state_nxt[s] = S_GUARD;
            w_gcnt_nxt[s]  = '0;
`else
            w_state_nxt[s] = S_IDLE;
`endif
          end else if (r_cnt[s] == SLOT_LAST) begin
            w_cnt_nxt[s] = '0;
          end else begin
            w_cnt_nxt[s] = r_cnt[s] + CNT_W'(1);
          end
        end
        S_GUARD: begin
`ifdef FADER_ARB_GUARD_EN
          if (r_gcnt[s] == GUARD_LAST) begin
            w_state_nxt[s] = S_IDLE;
            w_gcnt_nxt[s]  = '0;
          end else begin
            w_gcnt_nxt[s] = r_gcnt[s] + GCNT_W'(1);
          end
`else
          w_state_nxt[s] = S_IDLE;
`endif
        end
        default: begin
          w_state_nxt[s] = S_IDLE;
        end
      endcase
    end
  end

  // Post-edge grant vector, slot count, waiting flag and round-robin pointer
  always_comb begin
    w_grant_nxt  = '0;
    w_active_nxt = '0;
    for (int s = 0; s < MAX_ACTIVE; s++) begin
      if (w_state_nxt[s] == S_ACTIVE) begin
        w_grant_nxt[w_ch_nxt[s]] = 1'b1;
        w_active_nxt             = w_active_nxt + 4'd1;
      end
    end
    w_waiting_nxt = |(w_req & ~w_grant_nxt);
    w_rr_nxt      = w_alloc_done ? w_pick_ch : r_rr_ptr;
  end

  // State registers; synchronous reset drops every grant on the next edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < MAX_ACTIVE; s++) begin
        r_state[s] <= S_IDLE;
        r_ch[s]    <= '0;
        r_cnt[s]   <= '0;
`ifdef FADER_ARB_GUARD_EN
        r_gcnt[s]  <= '0;
`endif
      end
      r_rr_ptr     <= CH_W'(N_CH - 1);
      r_grant      <= '0;
      r_active_cnt <= '0;
      r_waiting    <= 1'b0;
    end else begin
      for (int s = 0; s < MAX_ACTIVE; s++) begin
        r_state[s] <= w_state_nxt[s];
        r_ch[s]    <= w_ch_nxt[s];
        r_cnt[s]   <= w_cnt_nxt[s];
`ifdef FADER_ARB_GUARD_EN
        r_gcnt[s]  <= w_gcnt_nxt[s];
`endif
      end
      r_rr_ptr     <= w_rr_nxt;
      r_grant      <= w_grant_nxt;
      r_active_cnt <= w_active_nxt;
      r_waiting    <= w_waiting_nxt;
    end
  end

  // Debug view of the slot FSMs
  always_comb begin
    dbg_slot_state = '0;
    for (int s = 0; s < MAX_ACTIVE; s++) begin
      dbg_slot_state[2*s +: 2] = r_state[s];
    end
  end

  // Motor pin gating against the registered grant
  always_comb begin
    grant      = r_grant;
    active_cnt = r_active_cnt;
    waiting    = r_waiting;
    pwm_out    = pwm_in  & r_grant;
    up_out     = up_in   & r_grant;
    down_out   = down_in & r_grant;
  end

endmodule

// File: tb/tb_fader_motor_arbiter.sv
// Testbench for fader_motor_arbiter: vector table, directed multi-cycle
// sequences, and randomized traffic checked against a slot-level model.
module tb_fader_motor_arbiter;

  localparam int N_CH  = 8;
  localparam int MAX_A = 2;
  localparam int SLOT  = 16;
  localparam int GUARD = 4;
`ifdef FADER_ARB_GUARD_EN
  localparam int GL = GUARD;
`else
  localparam int GL = 0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] faders_en, pwm_in, up_in, down_in;
  logic [7:0] pwm_out, up_out, down_out, grant;
  logic [3:0] active_cnt;
  logic       waiting;
  logic [3:0] dbg_slot_state;

  int n_checks;
  int n_errors;

  // Reference model: which channel each slot holds, how long it has held it,
  // how many guard edges remain before it is free again.
  int         m_owner [MAX_A];
  int         m_age   [MAX_A];
  int         m_guard [MAX_A];
  int         m_rr;
  logic       m_wait;
  logic [7:0] m_grant;
  int         m_active;

  logic [7:0] exp_q [$];

  typedef struct {
    logic       rst;
    logic [7:0] en;
    logic [7:0] up;
    logic [7:0] dn;
    logic [7:0] pwm;
    logic [7:0] exp_grant;
    int         exp_active;
    logic       exp_waiting;
  } vec_t;

  vec_t vecs [13];

  fader_motor_arbiter #(
    .N_CH(N_CH), .MAX_ACTIVE(MAX_A), .SLOT_CYCLES(SLOT), .GUARD_CYCLES(GUARD)
  ) dut (
    .clk(clk), .rst(rst), .faders_en(faders_en), .pwm_in(pwm_in),
    .up_in(up_in), .down_in(down_in), .pwm_out(pwm_out), .up_out(up_out),
    .down_out(down_out), .grant(grant), .active_cnt(active_cnt),
    .waiting(waiting), .dbg_slot_state(dbg_slot_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  function automatic logic bit_at(input logic [7:0] v, input int i);
    logic [7:0] t;
    t = v >> i;
    return t[0];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < MAX_A; s++) begin
      m_owner[s] = -1;
      m_age[s]   = 0;
      m_guard[s] = 0;
    end
    m_rr     = N_CH - 1;
    m_wait   = 1'b0;
    m_grant  = 8'h00;
    m_active = 0;
  endtask

  // One clock edge of the reference model, using the inputs seen at that edge
  task automatic model_step();
    logic [7:0] req, elig;
    bit         idle_now [MAX_A];
    int         pick, c;
    bit         placed;
    if (rst) begin
      model_reset();
      return;
    end
    req  = (up_in | down_in) & faders_en;
    elig = req & ~m_grant;
    for (int s = 0; s < MAX_A; s++) idle_now[s] = (m_owner[s] < 0) && (m_guard[s] == 0);
    for (int s = 0; s < MAX_A; s++) begin
      if (m_owner[s] >= 0) begin
        if (!bit_at(req, m_owner[s]) || ((m_age[s] == SLOT - 1) && m_wait)) begin
          m_owner[s] = -1;
          m_age[s]   = 0;
          m_guard[s] = GL;
        end else begin
          m_age[s] = (m_age[s] == SLOT - 1) ? 0 : m_age[s] + 1;
        end
      end else if (m_guard[s] > 0) begin
        m_guard[s]--;
      end
    end
    pick = -1;
    for (int k = 1; k <= N_CH; k++) begin
      c = (m_rr + k) % N_CH;
      if (pick < 0 && bit_at(elig, c)) pick = c;
    end
    placed = 0;
    if (pick >= 0) begin
      for (int s = 0; s < MAX_A; s++) begin
        if (!placed && idle_now[s]) begin
          m_owner[s] = pick;
          m_age[s]   = 0;
          m_rr       = pick;
          placed     = 1;
        end
      end
    end
    m_grant  = 8'h00;
    m_active = 0;
    for (int s = 0; s < MAX_A; s++) begin
      if (m_owner[s] >= 0) begin
        m_grant = m_grant | (8'h01 << m_owner[s]);
        m_active++;
      end
    end
    m_wait = ((req & ~m_grant) != 8'h00);
  endtask

  task automatic model_compare();
    check("model_grant",    int'(grant),      int'(m_grant));
    check("model_active",   int'(active_cnt), m_active);
    check("model_waiting",  int'(waiting),    int'(m_wait));
    check("model_pwm_out",  int'(pwm_out),    int'(pwm_in & m_grant));
    check("model_up_out",   int'(up_out),     int'(up_in & m_grant));
    check("model_down_out", int'(down_out),   int'(down_in & m_grant));
  endtask

  task automatic drive(input logic r, input logic [7:0] en, input logic [7:0] up,
                       input logic [7:0] dn, input logic [7:0] pwm);
    rst       = r;
    faders_en = en;
    up_in     = up;
    down_in   = dn;
    pwm_in    = pwm;
  endtask

  // Advance one edge, step the model, sample outputs on the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_compare();
  endtask

  initial begin
    logic [7:0] prev, rise;
    int         ch, len0, first_ch2, ok_cnt, gap;
    bit         ch0_done, found;

    n_checks = 0;
    n_errors = 0;
    model_reset();
    drive(1'b1, 8'h00, 8'h00, 8'h00, 8'h00);

    // ---- Table: start-up fill, reset mid-operation, enable drop ----
    vecs[0] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'hFF, 8'h3C, 8'hAA, 8'h01, 1, 1'b1};
    vecs[2] = '{1'b0, 8'hFF, 8'hFF, 8'h3C, 8'hAA, 8'h03, 2, 1'b1};
    vecs[3] = '{1'b0, 8'hFF, 8'hFF, 8'h3C, 8'hAA, 8'h03, 2, 1'b1};
    vecs[4] = '{1'b1, 8'hFF, 8'hFF, 8'h3C, 8'hAA, 8'h00, 0, 1'b0};
    vecs[5] = '{1'b0, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h01, 1, 1'b1};
    vecs[6] = '{1'b0, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h03, 2, 1'b1};
    vecs[7] = '{1'b0, 8'hFD, 8'hFF, 8'h00, 8'hFF, 8'h01, 1, 1'b1};
    for (int r = 8; r < 13; r++) begin
      if (r >= 8 + GL) vecs[r] = '{1'b0, 8'hFD, 8'hFF, 8'h00, 8'hFF, 8'h05, 2, 1'b1};
      else             vecs[r] = '{1'b0, 8'hFD, 8'hFF, 8'h00, 8'hFF, 8'h01, 1, 1'b1};
    end

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].dn, vecs[i].pwm);
      tick();
      check($sformatf("vec%0d_grant", i),    int'(grant),      int'(vecs[i].exp_grant));
      check($sformatf("vec%0d_active", i),   active_cnt,       vecs[i].exp_active);
      check($sformatf("vec%0d_waiting", i),  int'(waiting),    int'(vecs[i].exp_waiting));
      check($sformatf("vec%0d_pwm_out", i),  int'(pwm_out),    int'(vecs[i].pwm & vecs[i].exp_grant));
      check($sformatf("vec%0d_up_out", i),   int'(up_out),     int'(vecs[i].up & vecs[i].exp_grant));
      check($sformatf("vec%0d_down_out", i), int'(down_out),   int'(vecs[i].dn & vecs[i].exp_grant));
      if (i == 0) check("reset_dbg_idle", int'(dbg_slot_state), 0);
    end

    // ---- Rotation across ch0..ch3 with preemption ----
    drive(1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    drive(1'b0, 8'hFF, 8'h0F, 8'h00, 8'hFF);
    exp_q = {8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    prev = 8'h00; len0 = 0; first_ch2 = -1; ch0_done = 0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      rise = grant & ~prev;
      if (rise != 8'h00 && exp_q.size() > 0) begin
        ch = -1;
        for (int b = 0; b < N_CH; b++) if (bit_at(rise, b)) ch = b;
        check("rr_order", ch, int'(exp_q.pop_front()));
      end
      if (grant[0] && !ch0_done) len0++;
      else if (len0 > 0) ch0_done = 1;
      if (grant[2] && first_ch2 < 0) first_ch2 = c;
      prev = grant;
    end
    check("rr_order_remaining", exp_q.size(), 0);
    check("slice_length", len0, SLOT);
    check("ch2_first_grant_edge", first_ch2, SLOT + 2 + GL);

    // ---- Lone requester keeps its slot, no preemption ----
    drive(1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    drive(1'b0, 8'hFF, 8'h20, 8'h00, 8'h20);
    ok_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (grant == 8'h20 && waiting == 1'b0 && pwm_out == 8'h20) ok_cnt++;
    end
    check("solo_hold_cycles", ok_cnt, 100);

    // ---- Release with a waiter: regrant latency after the grant drops ----
    drive(1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    drive(1'b0, 8'hFF, 8'h05, 8'h00, 8'hFF);
    tick();
    tick();
    check("two_held", int'(grant), 8'h05);
    drive(1'b0, 8'hFF, 8'h15, 8'h00, 8'hFF);
    tick();
    check("waiter_flag", int'(waiting), 1);
    drive(1'b0, 8'hFF, 8'h11, 8'h00, 8'hFF);
    tick();
    check("ch2_dropped", int'(grant), 8'h01);
    gap = 0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      gap++;
      if (grant[4]) found = 1;
    end
    check("ch4_granted", int'(found), 1);
    check("regrant_gap", gap, 1 + GL);

    // ---- Randomized traffic against the model ----
    drive(1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    drive(1'b0, 8'hFF, 8'h00, 8'h00, 8'h00);
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 0) begin
        up_in     = 8'($urandom);
        down_in   = 8'($urandom) & 8'($urandom);
        faders_en = 8'($urandom) | 8'($urandom);
      end
      if ($urandom_range(0, 5) == 0) begin
        ch = $urandom_range(0, N_CH - 1);
        case ($urandom_range(0, 2))
          0:       up_in     = up_in ^ (8'h01 << ch);
          1:       down_in   = down_in ^ (8'h01 << ch);
          default: faders_en = faders_en ^ (8'h01 << ch);
        endcase
      end
      pwm_in = 8'($urandom);
      rst    = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
